bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential double-dabble converter: takes an unsigned binary word and produces packed BCD digits, one shift-add-3 step per clock. Sits directly upstream of the BCD-to-7-segment decoders. Each 4-bit digit of its output drives one decoder's A..D inputs, with bit 3 mapped to A (MSB).

Parameters:
WIDTH, 8, bit width of the binary input
DIGITS, 3, number of BCD output digits; integration must guarantee 10^DIGITS > 2^WIDTH - 1 (not checked in RTL)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  request conversion of bin_i; sampled only in IDLE
bin_i  in  WIDTH  unsigned binary operand, captured on the accepted start edge
busy  out  1  high while a conversion is in progress (SHIFT state)
done  out  1  one-cycle pulse: bcd_o has just been updated
bcd_o  out  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], digit 0 = units

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, bcd_o=0, internal shift/scratch registers=0, iteration counter=0. Reset applies immediately, including mid-conversion; the partial result is discarded and bcd_o returns to 0.
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: if start=1 at an edge, capture bin_i into the shift register, clear the BCD scratch, set counter=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: on each edge, apply add-3 correction, then shift; counter++. After the edge where counter reaches WIDTH-1, go to DONE.
  - DONE: one cycle only, then go to IDLE unconditionally.
- Per SHIFT edge:
  - Every scratch digit >= 5 has 3 added (4-bit, no carry out).
  - The corrected {scratch, binary} is shifted left by 1; the binary MSB enters scratch bit 0.
- bcd_o update: on the edge entering DONE, bcd_o is loaded from the final scratch and done=1 for that cycle. bcd_o then holds its value until the next DONE or reset.
- busy=1 exactly while state=SHIFT. It is a registered output, 0 in IDLE and DONE.
- Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH. That is WIDTH SHIFT cycles, and start-to-done = WIDTH+1 edges.
- Throughput: one conversion per WIDTH+2 cycles. start must be held or re-asserted in IDLE to be accepted.
- start asserted in SHIFT or DONE: ignored, not queued. bin_i changes after acceptance: no effect.
- All-zero and all-ones inputs convert correctly. Digits above the most significant nonzero digit are 0; no blanking is applied.
- Scratch digits never exceed 9 after any correction/shift pair. A value > 9 indicates an RTL bug; the bench asserts this.

Decomposition:
- Package dd_pkg:
  - state enum typedef (IDLE, SHIFT, DONE)
  - BCD_W=4
  - ADD3_THRESH=5, ADD3_VAL=3
- Sub-module dd_add3 (combinational): 4-bit digit in -> digit + 3 if >= 5, else unchanged. Instantiated DIGITS times via generate.
- Counter width is $clog2(WIDTH); the FSM and datapath live in bin_to_bcd_seq.

Test Plan:
1. Reset, then start with bin_i=0 -> done after 9 edges; bcd_o=12'h000; busy high for exactly 8 cycles.
2. bin_i=255 -> bcd_o=12'h255. Check the intermediate scratch after shift 5 = 3'h... and that no digit exceeds 9 at any cycle (assertion).
3. bin_i=9, then bin_i=100 back-to-back (start re-asserted the cycle after done) -> 12'h009, then 12'h100; bcd_o holds 12'h009 until the second done.
4. start pulsed at shift 3 of a bin_i=200 conversion, with bin_i changed to 17 -> ignored; result 12'h200; only one done pulse.
5. Assert rst at shift 4 of bin_i=137 -> immediately busy=0, done=0, bcd_o=0. After release, a new start with 137 -> 12'h137.
6. Exhaustive sweep 0..255 against a reference model; each digit fed to the 7-seg decoder model matches the expected segment pattern.

Source files
------------

// File: rtl/dd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package dd_pkg;

  localparam int BCD_W       = 4;
  localparam int ADD3_THRESH = 5;
  localparam int ADD3_VAL    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module dd_add3
  import dd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(ADD3_THRESH)) begin
      digit_o = digit_i + BCD_W'(ADD3_VAL);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one add-3/shift step per clock,
// result published on bcd_o together with a one-cycle done pulse.
module bin_to_bcd_seq
  import dd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin_i,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd_o
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [WIDTH-1:0]    bin_d;
  logic [BCD_TOT-1:0]  scratch_q;
  logic [BCD_TOT-1:0]  scratch_d;
  logic [BCD_TOT-1:0]  corr;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BCD_TOT-1:0]  bcd_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    dd_add3 u_add3 (
      .digit_i (scratch_q[g*BCD_W +: BCD_W]),
      .digit_o (corr[g*BCD_W +: BCD_W])
    );
  end

  // The binary MSB shifts into the units digit of the corrected scratch.
  always_comb begin
    scratch_d = {corr[BCD_TOT-2:0], bin_q[WIDTH-1]};
    bin_d     = bin_q << 1;
  end

  // NOTE: every register here, including the result and scratch, is cleared by
  // the async reset so an aborted conversion leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments let each branch read pre-edge values.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q     <= bin_i;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          bin_q     <= bin_d;
          cnt_q     <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            bcd_q   <= scratch_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd_o = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: arithmetic reference model compared
// every cycle, plus directed conversions with literal BCD expectations.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] bin_i = '0;
  logic             busy;
  logic             done;
  logic [BW-1:0]    bcd_o;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin_i (bin_i),
    .busy  (busy),
    .done  (done),
    .bcd_o (bcd_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by division, packed four bits per digit.
  function automatic logic [BW-1:0] to_bcd(input int n);
    logic [BW-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  // Segment pattern gfedcba for a digit presented as A(bit3)..D(bit0).
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference model: a conversion occupies WIDTH busy cycles, then one done
  // cycle publishing the decimal value of the captured operand.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [BW-1:0]    m_bcd  = '0;
  logic [WIDTH-1:0] m_bin  = '0;
  int               m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_bin  <= '0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_bcd  <= to_bcd(int'(m_bin));
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_left <= WIDTH;
      m_bin  <= bin_i;
    end
  end

  // After k shifts the scratch holds the BCD of the top k operand bits.
  always @(posedge clk) begin
    #2;
    if (cmp_en && !rst) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("bcd_o", 32'(bcd_o), 32'(m_bcd));
      if (m_busy) begin
        check("scratch", 32'(dut.scratch_q), 32'(to_bcd(int'(m_bin) >> m_left)));
        for (int d = 0; d < DIGITS; d++) begin
          check("digit_le9", 32'(dut.scratch_q[4*d +: 4] > 4'd9), 32'd0);
        end
      end
    end
  end

  task automatic launch(input logic [WIDTH-1:0] v);
    @(negedge clk);
    start = 1'b1;
    bin_i = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = int'(busy);
    while (!done && lat < 3 * WIDTH) begin
      @(negedge clk);
      lat++;
      busy_cnt += int'(busy);
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int bcnt;
    int dcnt;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_o), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Zero operand: latency and busy width.
    launch(8'd0);
    wait_done(lat, bcnt);
    check("zero_lat", 32'(lat), 32'(WIDTH));
    check("zero_busy", 32'(bcnt), 32'(WIDTH));
    check("zero_bcd", 32'(bcd_o), 32'h000);

    // All ones, with a peek at the scratch after five shifts (top bits 11111).
    launch(8'd255);
    repeat (5) @(negedge clk);
    check("scratch_sh5", 32'(dut.scratch_q), 32'h031);
    wait_done(lat, bcnt);
    check("ones_bcd", 32'(bcd_o), 32'h255);

    // Back-to-back conversions; previous result holds meanwhile.
    launch(8'd9);
    wait_done(lat, bcnt);
    check("nine_bcd", 32'(bcd_o), 32'h009);
    launch(8'd100);
    repeat (3) @(negedge clk);
    check("hold_009", 32'(bcd_o), 32'h009);
    wait_done(lat, bcnt);
    check("hundred_bcd", 32'(bcd_o), 32'h100);

    // start and bin_i disturbed mid-conversion are ignored.
    launch(8'd200);
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin_i = 8'd17;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    check("ignore_bcd", 32'(bcd_o), 32'h200);
    dcnt = int'(done);
    repeat (WIDTH + 4) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("single_done", 32'(dcnt), 32'd1);

    // Reset in the middle of a conversion.
    launch(8'd137);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(8'd137);
    wait_done(lat, bcnt);
    check("after_rst_bcd", 32'(bcd_o), 32'h137);

    // Full operand sweep, including the segment view of each digit.
    for (int v = 0; v < (1 << WIDTH); v++) begin
      launch(WIDTH'(v));
      wait_done(lat, bcnt);
      check("sweep_bcd", 32'(bcd_o), 32'(to_bcd(v)));
      for (int d = 0; d < DIGITS; d++) begin
        check("sweep_seg", 32'(seg7(bcd_o[4*d +: 4])), 32'(seg7(4'((v / (10 ** d)) % 10))));
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
